nios2_system_irq_arbiter: RTL and testbench
===========================================

# nios2_system_irq_arbiter

Interrupt arbiter that sits between several level-sensitive PIO interrupt outputs and a single Nios II IRQ line. It registers the incoming requests, applies a software mask, grants one source at a time and raises `irq`. It holds the grant until software acknowledges it by source ID through an Avalon-MM slave. After acknowledgement it waits a holdoff period so the serviced source can drop its level before the next arbitration.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources; legal range 1..16.
- `HOLDOFF`, 2: cycles spent in HOLD after a valid ACK; legal range 1..15.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `irq_in` input NUM_SRC: level interrupt requests from PIO blocks.
- `address` input 3: register word address.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect` is high and `write_n` is low.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data.
- `irq` output 1: interrupt to the CPU.

## Operation
- Request path: `irq_in_q` is `irq_in` registered once. The effective request is `req = irq_in_q & mask`.
- State machine states: IDLE=0, ACTIVE=1, HOLD=2.
  - IDLE -> ACTIVE when `|req` is true. On this transition the block latches `gnt_id` (the arbitration winner), increments `gnt_cnt` (16-bit, wraps at 0xFFFF to 0) and updates the round-robin pointer.
  - ACTIVE -> HOLD on a write to ACK with `writedata[3:0] == gnt_id`. It loads `hold_cnt = HOLDOFF`.
  - ACTIVE, ACK write with a mismatched ID: the state does not change and sticky `ack_err` is set.
  - HOLD: `hold_cnt` decrements each cycle. The block moves HOLD -> IDLE when the count reaches 1.
  - ACK writes in IDLE or HOLD are ignored and set `ack_err`.
- `irq` is high exactly while the state is ACTIVE, and is driven from a register.
- Masking or deasserting the granted source while ACTIVE has no effect: the grant persists until it is acknowledged.
- Arbitration:
  - Fixed mode: lowest set index of `req` wins.
  - Round-robin mode: search starts at `ptr`, moves upward and wraps at `NUM_SRC-1`. After a grant, `ptr = gnt_id+1` modulo `NUM_SRC`.
- Register map (bits at and above `NUM_SRC` read 0):
  - 0 PENDING, read-only: `irq_in_q` (unmasked).
  - 1 MASK, read/write: `[NUM_SRC-1:0]`.
  - 2 VECTOR, read-only: bit31 = (state==ACTIVE), `[3:0]` = `gnt_id`. `gnt_id` holds its last value after service.
  - 3 ACK, write-only: `[3:0]` = source ID. Reads return 0.
  - 4 STATUS: `[1:0]` = state, bit8 = `ack_err`, `[31:16]` = `gnt_cnt`. Writing 1 to bit8 clears `ack_err`; the other bits are read-only.
  - 5..7: reads return 0; writes are ignored.
- Simultaneous events:
  - If an `ack_err` set and a STATUS clear occur in the same cycle, the set wins.
  - A MASK write takes effect for the next cycle's arbitration.
- Reset values: `irq`=0, `readdata`=0, state=IDLE, `mask`=0, `irq_in_q`=0, `gnt_id`=0, `gnt_cnt`=0, `ptr`=0, `ack_err`=0, `hold_cnt`=0.
- Reset asserted mid-operation: on the next edge all of the above return to their reset values, so `irq` is low from the following cycle.

## Timing
- `readdata` is registered every cycle from `address`, giving one cycle of read latency with no wait states. It updates regardless of `chipselect`.
- Request latency: `irq_in` goes high before edge 0; `irq_in_q` goes high at edge 0; ACTIVE and `irq`=1 are reached at edge 1, provided the state was IDLE and the mask bit was set.
- ACK latency: an ACK write sampled at edge k gives `irq`=0 after edge k, i.e. HOLD is entered at k.
- The earliest next grant is at edge k+HOLDOFF+1.
- A MASK write followed immediately by a request, both sampled at the same edge, arbitrates on the new mask one edge later.

## Configuration
- `IRQ_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration using `ptr`.
  - Undefined: fixed priority, lowest index wins. `ptr` is not implemented and reads nowhere.
  - All other behaviour is identical in both modes.

## Test plan
- Reset, then `mask`=0 and `irq_in`=4'b0010: `irq` stays 0 and PENDING reads 0x2. Then write MASK=0xF: `irq`=1 two edges later and VECTOR reads 0x80000001.
- ACTIVE on ID 1, write ACK=3: state stays ACTIVE and STATUS bit8=1. Write STATUS=0x100: bit8 clears. Write ACK=1: `irq` falls after that edge and IDLE is reached HOLDOFF+1 edges later.
- `irq_in`=4'b1111 held, acknowledging each grant:
  - Fixed build: the grant sequence is 0,0,0,...
  - Round-robin build: the grant sequence is 0,1,2,3,0.
  - In both builds `gnt_cnt` increments by one per grant.
- Assert reset while ACTIVE with `gnt_cnt`=5: `irq`=0 on the following cycle, and STATUS and MASK read 0.
- Deassert or mask the granted source while ACTIVE: `irq` stays 1 until a matching ACK arrives. Reading address 6 returns 0.
- Preload `gnt_cnt`=0xFFFF via repeated grants and perform one more grant: STATUS`[31:16]` reads 0x0000.

Source files
------------

// File: rtl/nios2_system_irq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nios2_system_irq_arbiter
// Purpose  : Registers PIO level interrupts, masks them, grants one source at
//            a time onto irq and holds the grant until an Avalon-MM ACK by ID.
//            Define IRQ_ARB_ROUND_ROBIN_EN for round-robin arbitration
//            (default build is fixed priority, lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module nios2_system_irq_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int HOLDOFF = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   output logic               irq
);

   localparam logic [2:0] c_ADDR_PENDING = 3'd0;
   localparam logic [2:0] c_ADDR_MASK    = 3'd1;
   localparam logic [2:0] c_ADDR_VECTOR  = 3'd2;
   localparam logic [2:0] c_ADDR_ACK     = 3'd3;
   localparam logic [2:0] c_ADDR_STATUS  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [NUM_SRC-1:0] r_irq_in_q;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] w_req;
   logic [3:0]         r_gnt_id;
   logic [3:0]         r_hold_cnt;
   logic [3:0]         w_win_id;
   logic [15:0]        r_gnt_cnt;
   logic               r_ack_err;
   logic               r_irq;
   logic [31:0]        r_readdata;
   logic [31:0]        w_rdata;
   logic               w_wr;
   logic               w_ack_wr;
   logic               w_ack_match;
   logic               w_grant;
   logic               w_ack_err_set;
   logic               w_ack_err_clr;
   logic               w_unused_writedata;

   assign w_wr          = chipselect & ~write_n;
   assign w_ack_wr      = w_wr && (address == c_ADDR_ACK);
   assign w_ack_match   = (writedata[3:0] == r_gnt_id);
   assign w_ack_err_clr = w_wr && (address == c_ADDR_STATUS) && writedata[8];
   assign w_req         = r_irq_in_q & r_mask;
   assign w_unused_writedata = &{1'b0, writedata};

`ifdef IRQ_ARB_ROUND_ROBIN_EN
   logic [3:0] r_ptr;
   logic [4:0] w_dist;
   logic [4:0] w_best_dist;

   // Winner is the requester with the smallest upward distance from r_ptr.
   always_comb begin
      w_win_id    = '0;
      w_dist      = '0;
      w_best_dist = 5'(NUM_SRC);
      for (int j = 0; j < NUM_SRC; j++) begin
         if (4'(j) >= r_ptr)
            w_dist = 5'(j) - {1'b0, r_ptr};
         else
            w_dist = 5'(j) + 5'(NUM_SRC) - {1'b0, r_ptr};
         if (w_req[j] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_win_id    = 4'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (w_grant)
         r_ptr <= (w_win_id == 4'(NUM_SRC - 1)) ? 4'd0 : w_win_id + 4'd1;
   end
`else
   always_comb begin
      w_win_id = '0;
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
         if (w_req[j])
            w_win_id = 4'(j);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_grant       = 1'b0;
      w_ack_err_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_next_state = S_ACTIVE;
               w_grant      = 1'b1;
            end
            if (w_ack_wr)
               w_ack_err_set = 1'b1;
         end
         S_ACTIVE: begin
            if (w_ack_wr) begin
               if (w_ack_match)
                  w_next_state = S_HOLD;
               else
                  w_ack_err_set = 1'b1;
            end
         end
         S_HOLD: begin
            if (r_hold_cnt <= 4'd1)
               w_next_state = S_IDLE;
            if (w_ack_wr)
               w_ack_err_set = 1'b1;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         c_ADDR_PENDING: w_rdata[NUM_SRC-1:0] = r_irq_in_q;
         c_ADDR_MASK:    w_rdata[NUM_SRC-1:0] = r_mask;
         c_ADDR_VECTOR: begin
            w_rdata[31]  = (r_state == S_ACTIVE);
            w_rdata[3:0] = r_gnt_id;
         end
         c_ADDR_STATUS: begin
            w_rdata[1:0]   = r_state;
            w_rdata[8]     = r_ack_err;
            w_rdata[31:16] = r_gnt_cnt;
         end
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_in_q <= '0;
         r_mask     <= '0;
         r_gnt_id   <= '0;
         r_gnt_cnt  <= '0;
         r_hold_cnt <= '0;
         r_ack_err  <= 1'b0;
         r_irq      <= 1'b0;
         r_readdata <= '0;
      end else begin
         r_irq_in_q <= irq_in;
         r_readdata <= w_rdata;
         r_irq      <= (w_next_state == S_ACTIVE);
         if (w_wr && (address == c_ADDR_MASK))
            r_mask <= writedata[NUM_SRC-1:0];
         if (w_grant) begin
            r_gnt_id  <= w_win_id;
            r_gnt_cnt <= r_gnt_cnt + 16'd1;
         end
         if ((r_state == S_ACTIVE) && (w_next_state == S_HOLD))
            r_hold_cnt <= 4'(HOLDOFF);
         else if (r_state == S_HOLD)
            r_hold_cnt <= r_hold_cnt - 4'd1;
         // A new error in the same cycle as a software clear must survive.
         if (w_ack_err_set)
            r_ack_err <= 1'b1;
         else if (w_ack_err_clr)
            r_ack_err <= 1'b0;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_nios2_system_irq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nios2_system_irq_arbiter
// Purpose  : Scoreboard bench for nios2_system_irq_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_system_irq_arbiter;

   localparam int NUM_SRC = 4;
   localparam int HOLDOFF = 2;

   logic               clk;
   logic               reset;
   logic [NUM_SRC-1:0] irq_in;
   logic [2:0]         address;
   logic               chipselect;
   logic               write_n;
   logic [31:0]        writedata;
   logic [31:0]        readdata;
   logic               irq;

   nios2_system_irq_arbiter #(
      .NUM_SRC (NUM_SRC),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   logic    rd_v;
   int      checks = 0;
   int      errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Read data appears one edge after the address is presented.
   always @(posedge clk) begin
      logic    v;
      rd_exp_t e;
      v = rd_v;
      #1;
      if (v) begin
         if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_val(e.tag, readdata, e.exp);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
      rd_exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      address = a;
      rd_v    = 1'b1;
      @(negedge clk);
      rd_v    = 1'b0;
   endtask

   task automatic wait_irq(input string tag);
      int n;
      n = 0;
      while (irq !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, {31'b0, irq}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_id;
      reset      = 1'b1;
      irq_in     = '0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      rd_v       = 1'b0;
      step(3);
      check_val("rst_irq", {31'b0, irq}, 32'd0);
      check_val("rst_readdata", readdata, 32'd0);
      reset = 1'b0;
      bus_read(3'd4, 32'h0000_0000, "rst_status");
      bus_read(3'd1, 32'h0000_0000, "rst_mask");

      // Request present but masked off
      irq_in = 4'b0010;
      step(3);
      check_val("masked_irq", {31'b0, irq}, 32'd0);
      bus_read(3'd0, 32'h0000_0002, "pending");
      bus_write(3'd1, 32'h0000_000F);
      check_val("mask_lat_irq", {31'b0, irq}, 32'd0);
      step(1);
      check_val("grant_irq", {31'b0, irq}, 32'd1);
      bus_read(3'd2, 32'h8000_0001, "vector_id1");
      bus_read(3'd4, 32'h0001_0001, "status_active");

      // Wrong-ID acknowledge, then clear the sticky error
      bus_write(3'd3, 32'd3);
      bus_read(3'd4, 32'h0001_0101, "ack_err_set");
      check_val("bad_ack_irq", {31'b0, irq}, 32'd1);
      bus_write(3'd4, 32'h0000_0100);
      bus_read(3'd4, 32'h0001_0001, "ack_err_clr");

      // Grant survives source deassertion and masking
      irq_in = '0;
      bus_write(3'd1, 32'h0);
      step(2);
      check_val("held_grant", {31'b0, irq}, 32'd1);
      bus_read(3'd6, 32'h0000_0000, "addr6");
      bus_read(3'd2, 32'h8000_0001, "vector_held");

      bus_write(3'd3, 32'd1);
      check_val("ack_irq_low", {31'b0, irq}, 32'd0);
      for (int i = 0; i < HOLDOFF; i++)
         bus_read(3'd4, 32'h0001_0002, $sformatf("hold_%0d", i));
      bus_read(3'd4, 32'h0001_0000, "idle_after_hold");
      bus_read(3'd2, 32'h0000_0001, "vector_after");

      bus_write(3'd3, 32'd1);
      bus_read(3'd4, 32'h0001_0100, "ack_idle_err");
      bus_write(3'd4, 32'h0000_0100);

      // Grant sequence with all sources asserted, from a fresh reset
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      irq_in = '1;
      bus_write(3'd1, 32'h0000_000F);
      for (int i = 0; i < 5; i++) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
         exp_id = i % NUM_SRC;
`else
         exp_id = 0;
`endif
         wait_irq($sformatf("seq_irq%0d", i));
         bus_read(3'd2, 32'h8000_0000 | 32'(exp_id), $sformatf("seq_vec%0d", i));
         bus_read(3'd4, {16'(i + 1), 16'h0001}, $sformatf("seq_cnt%0d", i));
         if (i < 4)
            bus_write(3'd3, 32'(exp_id));
      end

      // Reset while ACTIVE with five grants counted
      reset = 1'b1;
      step(1);
      check_val("midrst_irq", {31'b0, irq}, 32'd0);
      reset = 1'b0;
      bus_read(3'd4, 32'h0000_0000, "midrst_status");
      bus_read(3'd1, 32'h0000_0000, "midrst_mask");
      check_val("midrst_irq_stay", {31'b0, irq}, 32'd0);

      // Grant counter wrap
      irq_in = 4'b0001;
      bus_write(3'd1, 32'h0000_0001);
      wait_irq("wrap_grant");
      force dut.r_gnt_cnt = 16'hFFFF;
      step(1);
      release dut.r_gnt_cnt;
      bus_read(3'd4, 32'hFFFF_0001, "preload");
      bus_write(3'd3, 32'd0);
      wait_irq("wrap_regrant");
      bus_read(3'd4, 32'h0000_0001, "cnt_wrap");
      bus_read(3'd2, 32'h8000_0000, "wrap_vec");

      step(2);
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
